uart_cmd_interface: RTL and testbench
=====================================

Name: uart_cmd_interface

Overview:
Parametrised UART-to-ALU command interface. Replaces the fixed tag/payload parser with:
- configurable tag values;
- inter-byte timeout;
- error reporting;
- configurable ALU result latency;
- a full TX handshake that holds the result until the transmitter reports done.

It sits between the UART RX/TX modules and the ALU.

Parameters:
- NB_DATA, 8: UART byte width and ALU operand/result width.
- NB_OP, 6: ALU operation code width (NB_OP <= NB_DATA).
- TAG_A, 8'h08: full-byte tag selecting operand A.
- TAG_B, 8'h10: full-byte tag selecting operand B.
- TAG_OP, 8'h20: full-byte tag selecting the operation, which triggers execution.
- NB_TIMER, 16: width of the payload timeout counter.
- TIMEOUT, 50000: clock cycles allowed between a tag byte and its payload byte. Must be >= 2.
- RESULT_LAT, 0: clock cycles of ALU latency after o_valid before i_result is valid. Range 0..15.

Ports:
- clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx  in  NB_DATA  byte from UART RX
- i_rxDone  in  1  one-cycle strobe; i_rx is valid
- i_txDone  in  1  one-cycle strobe; UART TX finished the byte
- o_tx_start  out  1  one-cycle strobe to start UART TX
- o_data  out  NB_DATA  registered result byte to UART TX
- o_datoA  out  NB_DATA  operand A to ALU
- o_datoB  out  NB_DATA  operand B to ALU
- o_operation  out  NB_OP  op code to ALU
- o_valid  out  1  one-cycle strobe; operands and op are valid
- i_result  in  NB_DATA  ALU result
- o_busy  out  1  high from o_valid until TX completion
- o_err  out  1  one-cycle error strobe
- o_err_code  out  2  error cause: 01 bad tag, 10 timeout, 11 overrun. Holds last value until next o_err.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE;
  - all outputs 0, including o_data, operand/op registers and o_err_code;
  - timer and latency counter 0.
  - Reset asserted mid-frame or mid-TX aborts immediately; no tx_start is issued afterwards.
- All outputs are registered.
- States: IDLE, PAYLOAD, EXEC, SEND, WAIT_TX.
- IDLE, on i_rxDone:
  - i_rx equals TAG_A, TAG_B or TAG_OP: latch the tag, clear the timer, go to PAYLOAD.
  - Otherwise: o_err=1 next cycle, o_err_code=01, stay in IDLE.
- PAYLOAD:
  - The timer increments each cycle without i_rxDone.
  - On i_rxDone with tag A: o_datoA<=i_rx, go to IDLE.
  - On i_rxDone with tag B: o_datoB<=i_rx, go to IDLE.
  - On i_rxDone with tag OP: o_operation<=i_rx[NB_OP-1:0], o_valid=1 for the next cycle only, go to EXEC.
  - Timer reaching TIMEOUT-1 with no i_rxDone: o_err, code 10, go to IDLE, registers unchanged.
  - i_rxDone in the same cycle as timer expiry: the byte wins, no error.
  - The payload byte is never interpreted as a tag.
- EXEC:
  - Entered in the same cycle o_valid is high.
  - Counts RESULT_LAT cycles, then captures o_data<=i_result and goes to SEND.
  - With RESULT_LAT=0, capture happens in the o_valid cycle.
  - Latency: op byte i_rxDone at cycle N gives o_valid at N+1, capture at N+1+RESULT_LAT, o_tx_start at N+2+RESULT_LAT.
- SEND: o_tx_start=1 for exactly one cycle, then go to WAIT_TX.
- WAIT_TX:
  - Holds o_data stable until i_txDone, then goes to IDLE; o_busy drops in the following cycle.
  - i_rxDone in EXEC/SEND/WAIT_TX: byte discarded, o_err code 11, no state change.
  - i_rxDone and i_txDone in the same cycle: overrun is reported and the FSM still returns to IDLE.
- o_busy=1 in EXEC, SEND and WAIT_TX; 0 otherwise.
- o_datoA, o_datoB and o_operation keep their values across frames. An OP frame reuses the last loaded operands.
- The timer saturates; it never wraps.

Test Plan:
- Reset, then bytes 08,05 / 10,03 / 20,00 with i_result=08 (RESULT_LAT=0) -> o_datoA=05, o_datoB=03; o_valid one cycle after the 3rd op byte; o_tx_start one cycle later; o_data=08; o_busy low after i_txDone.
- RESULT_LAT=3, op frame 20,01, i_result changes at N+4 to 2A -> o_data=2A, o_tx_start at N+5.
- Byte 33 in IDLE -> o_err pulse, o_err_code=01, state stays IDLE; a following 08,7F loads o_datoA=7F.
- TIMEOUT=10: byte 08, then silence -> o_err, code 10 at the 10th cycle; o_datoA unchanged. Repeat with payload arriving exactly in the expiry cycle -> loaded, no error.
- Byte arrives while in WAIT_TX -> o_err, code 11; o_data unchanged; return to IDLE on i_txDone.
- Assert i_rst one cycle after o_valid -> all outputs 0 immediately; no o_tx_start ever issued.

Source files
------------

// File: rtl/uart_cmd_interface.sv
// Byte-level command parser between a UART and an ALU: tag/payload framing with
// payload timeout, error reporting, configurable result latency and TX handshake.
module uart_cmd_interface #(
    parameter int                 NB_DATA    = 8,
    parameter int                 NB_OP      = 6,
    parameter logic [NB_DATA-1:0] TAG_A      = 8'h08,
    parameter logic [NB_DATA-1:0] TAG_B      = 8'h10,
    parameter logic [NB_DATA-1:0] TAG_OP     = 8'h20,
    parameter int                 NB_TIMER   = 16,
    parameter int                 TIMEOUT    = 50000,
    parameter int                 RESULT_LAT = 0
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx,
    input  logic               i_rxDone,
    input  logic               i_txDone,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    localparam logic [NB_TIMER-1:0] TIMER_MAX = NB_TIMER'(TIMEOUT - 1);
    localparam logic [3:0]          LAT_MAX   = 4'(RESULT_LAT);
    localparam logic [1:0] ERR_TAG     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;
    localparam logic [1:0] SEL_A  = 2'd0;
    localparam logic [1:0] SEL_B  = 2'd1;
    localparam logic [1:0] SEL_OP = 2'd2;

    typedef enum logic [2:0] {IDLE, PAYLOAD, EXEC, SEND, WAIT_TX} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           tag_reg, tag_next;
    logic [NB_TIMER-1:0]  timer_reg, timer_next;
    logic [3:0]           lat_reg, lat_next;
    logic                 tx_start_reg, tx_start_next;
    logic [NB_DATA-1:0]   data_reg, data_next;
    logic [NB_DATA-1:0]   dato_a_reg, dato_a_next;
    logic [NB_DATA-1:0]   dato_b_reg, dato_b_next;
    logic [NB_OP-1:0]     operation_reg, operation_next;
    logic                 valid_reg, valid_next;
    logic                 busy_reg, busy_next;
    logic                 err_reg, err_next;
    logic [1:0]           err_code_reg, err_code_next;

    logic is_tag;
    logic timer_expired;
    logic lat_done;
    logic [1:0] rx_sel;

    assign is_tag        = (i_rx == TAG_A) || (i_rx == TAG_B) || (i_rx == TAG_OP);
    assign rx_sel        = (i_rx == TAG_A) ? SEL_A : ((i_rx == TAG_B) ? SEL_B : SEL_OP);
    assign timer_expired = (timer_reg == TIMER_MAX);
    assign lat_done      = (lat_reg == LAT_MAX);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_rxDone && is_tag) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (i_rxDone) state_next = (tag_reg == SEL_OP) ? EXEC : IDLE;
                else if (timer_expired) state_next = IDLE;
            end
            EXEC: begin
                if (lat_done) state_next = SEND;
            end
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (i_txDone) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tag_next       = tag_reg;
        timer_next     = timer_reg;
        lat_next       = lat_reg;
        tx_start_next  = 1'b0;
        data_next      = data_reg;
        dato_a_next    = dato_a_reg;
        dato_b_next    = dato_b_reg;
        operation_next = operation_reg;
        valid_next     = 1'b0;
        err_next       = 1'b0;
        err_code_next  = err_code_reg;
        busy_next      = (state_next == EXEC) || (state_next == SEND) || (state_next == WAIT_TX);
        case (state_reg)
            IDLE: begin
                if (i_rxDone) begin
                    if (is_tag) begin
                        tag_next   = rx_sel;
                        timer_next = '0;
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = ERR_TAG;
                    end
                end
            end
            PAYLOAD: begin
                // A payload byte always wins over a simultaneous timer expiry.
                if (i_rxDone) begin
                    case (tag_reg)
                        SEL_A:   dato_a_next = i_rx;
                        SEL_B:   dato_b_next = i_rx;
                        default: begin
                            operation_next = i_rx[NB_OP-1:0];
                            valid_next     = 1'b1;
                            lat_next       = '0;
                        end
                    endcase
                end else if (timer_expired) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            EXEC: begin
                if (lat_done) begin
                    data_next     = i_result;
                    tx_start_next = 1'b1;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            default: ;
        endcase
        if ((state_reg == EXEC || state_reg == SEND || state_reg == WAIT_TX) && i_rxDone) begin
            err_next      = 1'b1;
            err_code_next = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tag_reg       <= SEL_A;
            timer_reg     <= '0;
            lat_reg       <= '0;
            tx_start_reg  <= 1'b0;
            data_reg      <= '0;
            dato_a_reg    <= '0;
            dato_b_reg    <= '0;
            operation_reg <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'b00;
        end else begin
            tag_reg       <= tag_next;
            timer_reg     <= timer_next;
            lat_reg       <= lat_next;
            tx_start_reg  <= tx_start_next;
            data_reg      <= data_next;
            dato_a_reg    <= dato_a_next;
            dato_b_reg    <= dato_b_next;
            operation_reg <= operation_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign o_tx_start  = tx_start_reg;
    assign o_data      = data_reg;
    assign o_datoA     = dato_a_reg;
    assign o_datoB     = dato_b_reg;
    assign o_operation = operation_reg;
    assign o_valid     = valid_reg;
    assign o_busy      = busy_reg;
    assign o_err       = err_reg;
    assign o_err_code  = err_code_reg;

endmodule

// File: tb/tb_uart_cmd_interface.sv
// Randomized scoreboard bench: frame-level model predicts valid/tx/error events
// with their cycle numbers; a negedge monitor pops and compares them.
module tb_uart_cmd_interface;

    localparam int         TIMEOUT = 10;
    localparam int         LAT     = 3;
    localparam logic [7:0] TAG_A   = 8'h08;
    localparam logic [7:0] TAG_B   = 8'h10;
    localparam logic [7:0] TAG_OP  = 8'h20;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_rx = '0;
    logic       i_rxDone = 1'b0;
    logic       i_txDone = 1'b0;
    logic       o_tx_start;
    logic [7:0] o_data, o_datoA, o_datoB;
    logic [5:0] o_operation;
    logic       o_valid;
    logic [7:0] i_result = '0;
    logic       o_busy, o_err;
    logic [1:0] o_err_code;

    uart_cmd_interface #(
        .NB_DATA(8), .NB_OP(6), .TAG_A(TAG_A), .TAG_B(TAG_B), .TAG_OP(TAG_OP),
        .NB_TIMER(16), .TIMEOUT(TIMEOUT), .RESULT_LAT(LAT)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_rx(i_rx), .i_rxDone(i_rxDone), .i_txDone(i_txDone),
        .o_tx_start(o_tx_start), .o_data(o_data), .o_datoA(o_datoA), .o_datoB(o_datoB),
        .o_operation(o_operation), .o_valid(o_valid), .i_result(i_result),
        .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] a; logic [7:0] b; logic [5:0] op; } valid_t;
    typedef struct { int cyc; logic [7:0] data; } tx_t;
    typedef struct { int cyc; logic [1:0] code; } err_t;

    valid_t valid_q[$];
    tx_t    tx_q[$];
    err_t   err_q[$];

    int checks = 0;
    int errors = 0;

    // Frame-level reference state
    logic [7:0] m_a = '0, m_b = '0, res_val = '0;
    int cap_cyc = -1, busy_start = -1, busy_end = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with empty scoreboard queue (cycle %0d)", name, cyc);
    endtask

    // Monitor
    valid_t     mv;
    tx_t        mt;
    err_t       me;
    logic       hold = 1'b0;
    logic [7:0] cur_data = '0;

    always @(negedge clk) begin
        if (i_rst) begin
            hold = 1'b0;
        end else begin
            if (o_valid) begin
                if (valid_q.size() == 0) unexpected("valid");
                else begin
                    mv = valid_q.pop_front();
                    chk("valid_cycle", cyc, mv.cyc);
                    chk("valid_datoA", o_datoA, mv.a);
                    chk("valid_datoB", o_datoB, mv.b);
                    chk("valid_op", o_operation, mv.op);
                end
            end
            if (o_tx_start) begin
                if (tx_q.size() == 0) unexpected("tx_start");
                else begin
                    mt = tx_q.pop_front();
                    chk("tx_cycle", cyc, mt.cyc);
                    chk("tx_data", o_data, mt.data);
                    cur_data = mt.data;
                    hold = 1'b1;
                end
            end else if (hold && o_busy) begin
                chk("data_hold", o_data, cur_data);
            end
            if (!o_busy) hold = 1'b0;
            if (o_err) begin
                if (err_q.size() == 0) unexpected("err");
                else begin
                    me = err_q.pop_front();
                    chk("err_cycle", cyc, me.cyc);
                    chk("err_code", o_err_code, me.code);
                end
            end
            chk("busy", o_busy, (cyc >= busy_start && cyc <= busy_end));
        end
    end

    task automatic cyc1(input logic rxd, input logic [7:0] rx, input logic txd);
        i_rxDone = rxd;
        i_rx     = rx;
        i_txDone = txd;
        i_result = (cyc == cap_cyc) ? res_val : (res_val ^ 8'($urandom_range(1, 255)));
        @(posedge clk);
        #1;
        i_rxDone = 1'b0;
        i_txDone = 1'b0;
    endtask

    // kind: 0 load A, 1 load B, 2 op, 3 non-tag byte. g = silent cycles before payload
    // (g >= TIMEOUT means no payload). ov_off: overrun byte at N+1+ov_off, <0 none.
    task automatic frame(input int kind, input int g, input logic [7:0] p,
                         input logic [7:0] res, input int d, input int ov_off);
        int n, t, ov;
        logic [7:0] tag;
        if (kind == 3) begin
            err_q.push_back('{cyc + 1, 2'b01});
            cyc1(1'b1, p, 1'b0);
            return;
        end
        tag = (kind == 0) ? TAG_A : ((kind == 1) ? TAG_B : TAG_OP);
        if (g >= TIMEOUT) begin
            err_q.push_back('{cyc + TIMEOUT + 1, 2'b10});
            cyc1(1'b1, tag, 1'b0);
            repeat (TIMEOUT) cyc1(1'b0, 8'($urandom), 1'b0);
            return;
        end
        cyc1(1'b1, tag, 1'b0);
        repeat (g) cyc1(1'b0, 8'($urandom), 1'b0);
        n = cyc;
        if (kind == 0) begin
            m_a = p;
            cyc1(1'b1, p, 1'b0);
            return;
        end
        if (kind == 1) begin
            m_b = p;
            cyc1(1'b1, p, 1'b0);
            return;
        end
        t  = n + 2 + LAT + d;
        ov = (ov_off < 0) ? -1 : n + 1 + ov_off;
        res_val = res;
        cap_cyc = n + 1 + LAT;
        valid_q.push_back('{n + 1, m_a, m_b, p[5:0]});
        tx_q.push_back('{n + 2 + LAT, res});
        busy_start = n + 1;
        busy_end   = t;
        if (ov >= 0) err_q.push_back('{ov + 1, 2'b11});
        cyc1(1'b1, p, 1'b0);
        while (cyc <= t) cyc1(cyc == ov, 8'($urandom), cyc == t);
    endtask

    task automatic reset_frame(input logic [7:0] p);
        int n;
        cyc1(1'b1, TAG_OP, 1'b0);
        n = cyc;
        valid_q.push_back('{n + 1, m_a, m_b, p[5:0]});
        busy_start = n + 1;
        busy_end   = n + 1000;
        cap_cyc    = -1;
        cyc1(1'b1, p, 1'b0);
        cyc1(1'b0, 8'($urandom), 1'b0);
        i_rst = 1'b1;
        busy_end = -1;
        tx_q.delete();
        #1;
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_tx_start", o_tx_start, 0);
        chk("rst_mid_operands", {o_datoA, o_datoB, o_operation}, 0);
        chk("rst_mid_data_err", {o_data, o_valid, o_err, o_err_code}, 0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        m_a = '0;
        m_b = '0;
        repeat (30) cyc1(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int kind, r, g, d, ov_off;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_outputs", {o_tx_start, o_data, o_valid, o_err, o_err_code}, 0);
        chk("rst_operands", {o_datoA, o_datoB, o_operation}, 0);
        i_rst = 1'b0;
        cyc1(1'b0, 8'h00, 1'b0);

        frame(0, 0, 8'h05, 8'h00, 1, -1);
        frame(1, 0, 8'h03, 8'h00, 1, -1);
        frame(2, 0, 8'h00, 8'h08, 2, -1);
        frame(2, 1, 8'h01, 8'h2A, 1, -1);
        frame(3, 0, 8'h33, 8'h00, 1, -1);
        frame(0, 0, 8'h7F, 8'h00, 1, -1);
        frame(0, TIMEOUT, 8'h00, 8'h00, 1, -1);
        frame(0, TIMEOUT - 1, 8'h44, 8'h00, 1, -1);
        frame(2, 0, 8'h15, 8'hC3, 3, LAT + 2);
        frame(2, 2, 8'h3F, 8'h5A, 2, LAT + 3);
        frame(2, 0, 8'h07, 8'h99, 1, 0);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 5)      g = $urandom_range(0, 3);
            else if (r < 7) g = TIMEOUT - 1;
            else if (r < 9) g = $urandom_range(0, TIMEOUT - 1);
            else            g = (kind == 2) ? 0 : TIMEOUT;
            d = $urandom_range(1, 5);
            ov_off = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LAT + 1 + d) : -1;
            b = 8'($urandom);
            while (kind == 3 && (b == TAG_A || b == TAG_B || b == TAG_OP)) b = 8'($urandom);
            frame(kind, g, b, 8'($urandom), d, ov_off);
            repeat ($urandom_range(0, 2)) cyc1(1'b0, 8'($urandom), 1'b0);
        end

        frame(0, 0, 8'hA5, 8'h00, 1, -1);
        reset_frame(8'h2C);
        frame(2, 0, 8'h11, 8'h6E, 2, -1);
        repeat (20) cyc1(1'b0, 8'($urandom), 1'b0);

        chk("valid_q_left", valid_q.size(), 0);
        chk("tx_q_left", tx_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
